// File: rtl/regfile_xfer_pkg.sv
// Shared definitions for the register-file debug transfer engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_xfer_pkg;

  // Register file geometry, shared with the register file itself.
  localparam int RF_NREGS = 32;
  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;

  // Command opcodes carried on cmd_op.
  localparam logic OP_DUMP = 1'b0;
  localparam logic OP_LOAD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_xfer.sv
// Debug engine that dumps all registers to a stream or loads them from one.
// Latency: accept->first dump word 1 cycle, 1 word/cycle; load commits on each din handshake.
// Backpressure: dump output register holds while dout_ready is low; load pulls at din_valid rate.
module regfile_xfer
  import regfile_xfer_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input  logic          clk,
  input  logic          res,
  input  logic          cmd_valid,
  input  logic          cmd_op,
  output logic          cmd_ready,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rf_readn,
  input  logic [DW-1:0] rf_read_data,
  output logic [AW-1:0] rf_writen,
  output logic [DW-1:0] rf_write_data,
  output logic          rf_write_flag,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] dout_data,
  output logic          dout_last,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic [DW-1:0] din_data
);

  // Counters carry one extra bit so they can reach NREGS without wrapping.
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] CNT_MAX  = (AW+1)'(NREGS);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(NREGS - 1);

  state_e        state_q, state_d;
  logic [AW:0]   fetch_idx_q, fetch_idx_d;
  logic [AW:0]   out_idx_q, out_idx_d;
  logic          dout_valid_q, dout_valid_d;
  logic          dout_last_q, dout_last_d;
  logic [DW-1:0] dout_data_q, dout_data_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          din_ready_q, din_ready_d;

  logic          dout_fire;
  logic          dump_load;
  logic          din_fire;

  assign dout_fire = dout_valid_q && dout_ready;
  assign dump_load = (state_q == ST_DUMP) && (fetch_idx_q < CNT_MAX) &&
                     (!dout_valid_q || dout_ready);
  // din_ready_q is high exactly while the engine sits in LOAD.
  assign din_fire  = din_ready_q && din_valid;

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d      = state_q;
    fetch_idx_d  = fetch_idx_q;
    out_idx_d    = out_idx_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    dout_data_d  = dout_data_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = (cmd_op == OP_LOAD) ? ST_LOAD : ST_DUMP;
          fetch_idx_d = '0;
          out_idx_d   = '0;
        end
      end
      ST_DUMP: begin
        if (dump_load) begin
          dout_valid_d = 1'b1;
          dout_data_d  = rf_read_data;
          dout_last_d  = (fetch_idx_q == CNT_LAST);
          fetch_idx_d  = fetch_idx_q + CNT_ONE;
        end else if (dout_fire) begin
          dout_valid_d = 1'b0;
          dout_last_d  = 1'b0;
        end
        // Nothing is left to fetch once the last word is accepted.
        if (dout_fire && dout_last_q) begin
          state_d = ST_DONE;
        end
      end
      ST_LOAD: begin
        if (din_fire) begin
          out_idx_d = out_idx_q + CNT_ONE;
          if (out_idx_q == CNT_LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    din_ready_d = (state_d == ST_LOAD);
  end

  // State, counters and registered outputs; reset aborts any transfer.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= ST_IDLE;
      fetch_idx_q  <= '0;
      out_idx_q    <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_data_q  <= '0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      din_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_idx_q  <= fetch_idx_d;
      out_idx_q    <= out_idx_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      dout_data_q  <= dout_data_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      din_ready_q  <= din_ready_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign din_ready  = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign dout_data  = dout_data_q;

  // Register-file port: read index only while dumping, write only on a load handshake.
  assign rf_readn      = (state_q == ST_DUMP) ? fetch_idx_q[AW-1:0] : '0;
  assign rf_write_flag = din_fire;
  assign rf_writen     = din_fire ? out_idx_q[AW-1:0] : '0;
  assign rf_write_data = din_fire ? din_data : '0;

endmodule

// File: doc/regfile_xfer.md
# regfile_xfer

Debug transfer engine on the initiator side of the 32×32 register file's read/write port. On command it either dumps all 32 registers out on a valid/ready stream (DUMP) or loads all 32 registers from an input stream (LOAD). It asserts `busy` so the core stalls and the register-file port mux selects this engine while a transfer runs.

## Interface
Parameters:
- `NREGS`, 32: registers transferred per command, indices 0..NREGS-1.
- `AW`, 5: register index width.
- `DW`, 32: data width.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `res`, in, 1: reset, asynchronous, active-low.
- `cmd_valid`, in, 1: command request.
- `cmd_op`, in, 1: 0 = DUMP, 1 = LOAD.
- `cmd_ready`, out, 1: command accepted when `cmd_valid && cmd_ready`.
- `busy`, out, 1: high in DUMP, LOAD and DONE.
- `done`, out, 1: one-cycle pulse at the end of a transfer.
- `rf_readn`, out, AW: register-file read index (combinational read data).
- `rf_read_data`, in, DW: register-file read data.
- `rf_writen`, out, AW: write index.
- `rf_write_data`, out, DW: write data.
- `rf_write_flag`, out, 1: write enable, sampled by the register file on the rising edge.
- `dout_valid`, `dout_ready`, `dout_data[DW]`, `dout_last`: dump stream (out, in, out, out).
- `din_valid`, `din_ready`, `din_data[DW]`: load stream (in, out, in).

## Operation
- States: IDLE, DUMP, LOAD, DONE. Reset puts the engine in IDLE.
- Values while `res` is low: `cmd_ready` = 0, all other outputs = 0, index counters = 0. `cmd_ready` goes to 1 on the first edge after `res` deasserts.
- IDLE:
  - `cmd_ready` = 1.
  - On accept: go to DUMP or LOAD per `cmd_op`, clear `fetch_idx` and `out_idx`.
- DUMP:
  - `rf_readn` = `fetch_idx`.
  - Output register `dout_data`/`dout_valid`/`dout_last` loads `rf_read_data` whenever `fetch_idx < NREGS && (!dout_valid || dout_ready)`, then `fetch_idx` increments.
  - `dout_last` = 1 on the word with index NREGS-1.
  - When the last word handshakes, go to DONE.
  - `dout_valid` never drops while words remain, except on the first cycle.
  - `dout_data` is stable while `dout_valid && !dout_ready`.
- LOAD:
  - `din_ready` = 1.
  - On `din_valid && din_ready`: `rf_write_flag` = 1, `rf_writen` = `out_idx`, `rf_write_data` = `din_data` (all combinational from the handshake), then `out_idx` increments.
  - Register 0 is written like any other register.
  - After the handshake at index NREGS-1, go to DONE.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- `rf_write_flag` = 0 outside LOAD handshakes. `rf_readn` = 0 outside DUMP.
- `cmd_valid` is ignored unless the state is IDLE; there is no queueing.
- Reset mid-transfer aborts immediately, with no `done` pulse.
  - Registers already loaded keep their new values.
  - Partial dump output is discarded.
- Counters are AW+1 bits wide so they reach NREGS without wrapping.

## Timing
- Command accept to first `dout_valid`: 1 cycle. Throughput is 1 word/cycle with `dout_ready` held high.
- A full DUMP takes 1 + 32 + 1 (DONE) = 34 cycles from accept to `done`.
- LOAD: each `din` handshake commits to the register file on that same edge. A readback of that register is valid on the next cycle.
- A full LOAD with `din_valid` held high takes 32 cycles, with `done` on the 33rd cycle after accept.
- Back-to-back commands: `cmd_ready` returns 1 the cycle after `done`.

## Structure
- Shared package holds:
  - the state encoding: IDLE = 0, DUMP = 1, LOAD = 2, DONE = 3;
  - the `cmd_op` constants OP_DUMP and OP_LOAD;
  - NREGS, AW and DW defaults, shared with the register file.
- Single module, no sub-modules. The dump output register is inline; a separate skid buffer is not needed.

## Test plan
- Reset, preload rf[i] = 0x1000+i, DUMP with `dout_ready` = 1 -> 32 words 0x1000..0x101F in order, `dout_last` only on 0x101F, `done` at cycle 34.
- DUMP with `dout_ready` toggling 1,0,0,1… -> no word lost or duplicated, data stable while stalled, same 32-word sequence.
- LOAD with `din_data` = 0xA5A50000+i, gapped `din_valid` -> exactly 32 `rf_write_flag` pulses to indices 0..31, then a DUMP returns those values.
- `cmd_valid` held high through a DUMP -> ignored until IDLE, then the next command is accepted the cycle after `done`.
- `res` low after 10 LOAD words -> all outputs 0 immediately, rf[0..9] updated, rf[10..31] unchanged, no `done`.
- LOAD on index 0 -> rf[0] reads back the loaded value (no hardwired zero).
